mem_arbiter: RTL and testbench

//  Sits directly downstream of the icache and dcache miss FSMs and shares the single

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/beat_counter.sv | 27 ++
 rtl/mem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the icache/dcache memory arbiter.
package mem_arb_pkg;

  localparam int unsigned WORDS       = 8;
  localparam int unsigned BLOCK_OFF_W = 4;
  localparam int unsigned WORD_IDX_W  = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_e;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } owner_e;

endpackage

// File: rtl/beat_counter.sv
// Small up-counter with synchronous clear and a terminal-count flag; used to
// count issued and returned words of a block fill.
module beat_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == '1);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory4c between the icache and dcache miss FSMs: block fills become
// eight pipelined word reads, dcache writes pass through as single-word writes.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_grant,
  output logic                  i_valid,
  output logic [DATA_W-1:0]     i_data,
  output logic [WORD_IDX_W-1:0] i_word,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_grant,
  output logic                  d_valid,
  output logic [DATA_W-1:0]     d_data,
  output logic [WORD_IDX_W-1:0] d_word,
  output logic                  d_done,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rvalid
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              last_owner_q, last_owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_sent_q, wr_sent_d;
  logic                issue_done_q, issue_done_d;
  logic                stray_q;

  logic                  cnt_clr;
  logic                  issue_inc;
  logic                  recv_inc;
  logic [WORD_IDX_W-1:0] issue_cnt;
  logic [WORD_IDX_W-1:0] recv_cnt;
  logic                  issue_tc;
  logic                  recv_tc;

  beat_counter #(.W(WORD_IDX_W)) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .inc_i (issue_inc),
    .cnt_o (issue_cnt),
    .tc_o  (issue_tc)
  );

  beat_counter #(.W(WORD_IDX_W)) u_recv_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .inc_i (recv_inc),
    .cnt_o (recv_cnt),
    .tc_o  (recv_tc)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_sent_d    = wr_sent_q;
    issue_done_d = issue_done_q;
    cnt_clr      = 1'b0;
    issue_inc    = 1'b0;
    recv_inc     = 1'b0;
    i_grant      = 1'b0;
    i_valid      = 1'b0;
    i_data       = '0;
    i_word       = '0;
    i_done       = 1'b0;
    d_grant      = 1'b0;
    d_valid      = 1'b0;
    d_data       = '0;
    d_word       = '0;
    d_done       = 1'b0;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state_q)
      IDLE: begin
        // A lone requester wins; on contention the side that did not go last wins.
        if (d_req && (!i_req || last_owner_q == ICACHE)) begin
          d_grant      = 1'b1;
          owner_d      = DCACHE;
          addr_d       = d_addr;
          wdata_d      = d_wdata;
          state_d      = d_wr ? WRITE : FILL;
          cnt_clr      = 1'b1;
          wr_sent_d    = 1'b0;
          issue_done_d = 1'b0;
        end else if (i_req) begin
          i_grant      = 1'b1;
          owner_d      = ICACHE;
          addr_d       = i_addr;
          wdata_d      = '0;
          state_d      = FILL;
          cnt_clr      = 1'b1;
          wr_sent_d    = 1'b0;
          issue_done_d = 1'b0;
        end
      end

      FILL: begin
        if (!issue_done_q) begin
          mem_enable = 1'b1;
          mem_addr   = {addr_q[ADDR_W-1:BLOCK_OFF_W], {BLOCK_OFF_W{1'b0}}}
                     + ADDR_W'({issue_cnt, 1'b0});
          issue_inc  = 1'b1;
          if (issue_tc) begin
            issue_done_d = 1'b1;
          end
        end
        if (mem_rvalid) begin
          recv_inc = 1'b1;
          if (owner_q == ICACHE) begin
            i_valid = 1'b1;
            i_data  = mem_rdata;
            i_word  = recv_cnt;
            i_done  = recv_tc;
          end else begin
            d_valid = 1'b1;
            d_data  = mem_rdata;
            d_word  = recv_cnt;
            d_done  = recv_tc;
          end
          if (recv_tc) begin
            last_owner_d = owner_q;
            state_d      = IDLE;
          end
        end
      end

      WRITE: begin
        if (!wr_sent_q) begin
          mem_enable = 1'b1;
          mem_wr     = 1'b1;
          mem_addr   = addr_q;
          mem_wdata  = wdata_q;
          wr_sent_d  = 1'b1;
        end else begin
          d_done       = 1'b1;
          last_owner_d = DCACHE;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Outputs are combinational from state and requests, so hold them quiet during reset.
    if (rst) begin
      i_grant    = 1'b0;
      i_valid    = 1'b0;
      i_data     = '0;
      i_word     = '0;
      i_done     = 1'b0;
      d_grant    = 1'b0;
      d_valid    = 1'b0;
      d_data     = '0;
      d_word     = '0;
      d_done     = 1'b0;
      mem_enable = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= ICACHE;
      // Pointer starts on the icache so the dcache wins the first contested round.
      last_owner_q <= ICACHE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_sent_q    <= 1'b0;
      issue_done_q <= 1'b0;
      stray_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_sent_q    <= wr_sent_d;
      issue_done_q <= issue_done_d;
      stray_q      <= mem_rvalid && (state_q != FILL);
    end
  end

  // A response outside a fill is dropped; stray_q records it for simulation visibility.
  stray_rvalid_seen: cover property (@(posedge clk) disable iff (rst) stray_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomised checks of mem_arbiter against a latency-4 memory model
// and a word-level reference of expected memory contents.
module tb_mem_arbiter;

  localparam int unsigned MEM_LAT = 4;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_grant, i_valid, i_done;
  logic [15:0] i_data;
  logic [2:0]  i_word;
  logic        d_req, d_wr;
  logic [15:0] d_addr, d_wdata;
  logic        d_grant, d_valid, d_done;
  logic [15:0] d_data;
  logic [2:0]  d_word;
  logic        mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_grant    (i_grant),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_word     (i_word),
    .i_done     (i_done),
    .d_req      (d_req),
    .d_wr       (d_wr),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_grant    (d_grant),
    .d_valid    (d_valid),
    .d_data     (d_data),
    .d_word     (d_word),
    .d_done     (d_done),
    .mem_enable (mem_enable),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: untouched words hold init_word(), writes go to an associative store.
  logic [15:0] seed;
  logic [15:0] mem_store [int];
  logic [15:0] ref_mem [int];
  int          due_q [$];
  logic [15:0] dat_q [$];
  int          cyc = 0;
  logic        rv_q = 1'b0;
  logic [15:0] rd_q = '0;
  logic        inject;

  function automatic logic [15:0] init_word(input logic [14:0] w);
    if (w[14:3] == 12'h123) return 16'hA000 + {13'b0, w[2:0]};
    return (16'({1'b0, w}) * 16'h9E37) ^ seed;
  endfunction

  function automatic logic [15:0] mem_word(input logic [14:0] w);
    return mem_store.exists(int'(w)) ? mem_store[int'(w)] : init_word(w);
  endfunction

  function automatic logic [15:0] exp_word(input logic [14:0] w);
    return ref_mem.exists(int'(w)) ? ref_mem[int'(w)] : init_word(w);
  endfunction

  always @(negedge clk) begin
    #2;
    if (rst) begin
      due_q.delete();
      dat_q.delete();
    end else if (mem_enable) begin
      if (mem_wr) mem_store[int'(mem_addr[15:1])] = mem_wdata;
      else begin
        due_q.push_back(cyc + int'(MEM_LAT));
        dat_q.push_back(mem_word(mem_addr[15:1]));
      end
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    rv_q = 1'b0;
    rd_q = '0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      rv_q = 1'b1;
      rd_q = dat_q.pop_front();
      void'(due_q.pop_front());
    end
  end

  assign mem_rvalid = rv_q | inject;
  assign mem_rdata  = inject ? 16'h5A5A : rd_q;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_ctl"}, 32'({i_grant, i_valid, i_done, d_grant, d_valid, d_done, mem_enable, mem_wr}), 0);
    chk({tag, "_data"}, {i_data, d_data}, 0);
    chk({tag, "_mem"}, {mem_addr, mem_wdata}, 0);
    chk({tag, "_word"}, 32'({i_word, d_word}), 0);
  endtask

  task automatic expect_grant(input bit use_d);
    chk("grant_owner", use_d ? d_grant : i_grant, 1);
    chk("grant_other", use_d ? i_grant : d_grant, 0);
    chk("grant_mem_quiet", mem_enable, 0);
  endtask

  // Cycles 1..12 after a fill grant: reads on 1..8, data on 5..12, done on 12.
  task automatic fill_body(input bit use_d, input logic [15:0] a, input bit drop);
    logic [15:0] base;
    base = {a[15:4], 4'h0};
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      #1;
      if (c <= 8) begin
        chk("fill_en", mem_enable, 1);
        chk("fill_wr", mem_wr, 0);
        chk("fill_addr", mem_addr, base + 16'(2 * (c - 1)));
      end else begin
        chk("fill_tail_en", mem_enable, 0);
        chk("fill_tail_addr", mem_addr, 0);
      end
      if (c >= 5) begin
        chk("fill_valid", use_d ? d_valid : i_valid, 1);
        chk("fill_word", use_d ? d_word : i_word, 32'(c - 5));
        chk("fill_data", use_d ? d_data : i_data, exp_word({a[15:4], 3'(c - 5)}));
      end else begin
        chk("fill_early_valid", use_d ? d_valid : i_valid, 0);
      end
      chk("fill_other_valid", use_d ? i_valid : d_valid, 0);
      chk("fill_done", use_d ? d_done : i_done, (c == 12) ? 1 : 0);
      chk("fill_other_done", use_d ? i_done : d_done, 0);
      if (c == 12 && drop) begin
        if (use_d) d_req = 1'b0;
        else i_req = 1'b0;
      end
    end
  endtask

  task automatic write_body(input logic [15:0] a, input logic [15:0] w);
    @(negedge clk);
    #1;
    chk("wr_en", mem_enable, 1);
    chk("wr_strobe", mem_wr, 1);
    chk("wr_addr", mem_addr, a);
    chk("wr_data", mem_wdata, w);
    chk("wr_early_done", d_done, 0);
    @(negedge clk);
    #1;
    chk("wr_after_en", mem_enable, 0);
    chk("wr_after_wdata", mem_wdata, 0);
    chk("wr_done", d_done, 1);
    d_req = 1'b0;
    d_wr  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    d_wr  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    outs_zero("reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ia, da, wa, wd, base5;
    int unsigned kind;
    bit use_d;

    seed    = 16'($urandom);
    rst     = 1'b1;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_wr    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    inject  = 1'b0;

    // Requests raised during reset must not be granted.
    repeat (3) @(negedge clk);
    i_req = 1'b1;
    d_req = 1'b1;
    #1;
    chk("rst_gate_i", i_grant, 0);
    chk("rst_gate_d", d_grant, 0);
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    outs_zero("reset");

    // Icache fill of the preloaded block.
    @(negedge clk);
    i_req  = 1'b1;
    i_addr = 16'h1236;
    #1;
    expect_grant(1'b0);
    fill_body(1'b0, 16'h1236, 1'b1);

    // Dcache write-through, then read it back with a dcache fill.
    @(negedge clk);
    d_req   = 1'b1;
    d_wr    = 1'b1;
    d_addr  = 16'h0042;
    d_wdata = 16'hBEEF;
    #1;
    expect_grant(1'b1);
    ref_mem[int'(15'h0021)] = 16'hBEEF;
    write_body(16'h0042, 16'hBEEF);
    @(negedge clk);
    d_req  = 1'b1;
    d_wr   = 1'b0;
    d_addr = 16'h0040;
    #1;
    expect_grant(1'b1);
    fill_body(1'b1, 16'h0040, 1'b1);

    // Simultaneous requests after reset: dcache first, icache right after d_done.
    do_reset();
    ia = 16'($urandom);
    da = 16'($urandom);
    @(negedge clk);
    i_req  = 1'b1;
    i_addr = ia;
    d_req  = 1'b1;
    d_addr = da;
    #1;
    expect_grant(1'b1);
    fill_body(1'b1, da, 1'b1);
    @(negedge clk);
    #1;
    expect_grant(1'b0);
    fill_body(1'b0, ia, 1'b1);

    // Both held high continuously: grants alternate D, I, D, I.
    do_reset();
    @(negedge clk);
    i_req  = 1'b1;
    i_addr = 16'($urandom);
    d_req  = 1'b1;
    d_addr = 16'($urandom);
    for (int n = 0; n < 4; n++) begin
      if (n > 0) @(negedge clk);
      #1;
      use_d = (n % 2 == 0);
      expect_grant(use_d);
      fill_body(use_d, use_d ? d_addr : i_addr, 1'b0);
      if (use_d) d_addr = 16'($urandom);
      else i_addr = 16'($urandom);
    end
    i_req = 1'b0;
    d_req = 1'b0;

    // Reset during the third issue cycle aborts the fill silently.
    base5 = 16'($urandom);
    @(negedge clk);
    i_req  = 1'b1;
    i_addr = base5;
    #1;
    expect_grant(1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      #1;
      chk("abort_issue_addr", mem_addr, {base5[15:4], 4'h0} + 16'(2 * (c - 1)));
    end
    rst   = 1'b1;
    i_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    outs_zero("post_rst");
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      chk("abort_no_valid", 32'({i_valid, d_valid}), 0);
      chk("abort_no_done", 32'({i_done, d_done}), 0);
      chk("abort_no_mem", mem_enable, 0);
    end
    @(negedge clk);
    i_req  = 1'b1;
    i_addr = base5;
    #1;
    expect_grant(1'b0);
    fill_body(1'b0, base5, 1'b1);

    // Stray response while idle is not forwarded but is recorded.
    @(negedge clk);
    inject = 1'b1;
    #1;
    chk("stray_i_valid", i_valid, 0);
    chk("stray_d_valid", d_valid, 0);
    @(negedge clk);
    inject = 1'b0;
    #1;
    chk("stray_flag", dut.stray_q, 1);

    // Random single-requester traffic over a few overlapping blocks.
    for (int n = 0; n < 10; n++) begin
      kind = $urandom_range(0, 2);
      wa   = 16'h2000 | 16'($urandom_range(0, 63));
      wd   = 16'($urandom);
      @(negedge clk);
      if (kind == 0) begin
        i_req  = 1'b1;
        i_addr = wa;
      end else begin
        d_req   = 1'b1;
        d_wr    = (kind == 2);
        d_addr  = (kind == 2) ? (wa & 16'hFFFE) : wa;
        d_wdata = wd;
      end
      #1;
      expect_grant(kind != 0);
      if (kind == 2) begin
        ref_mem[int'(wa[15:1])] = wd;
        write_body(wa & 16'hFFFE, wd);
      end else begin
        fill_body(kind == 1, wa, 1'b1);
      end
    end

    @(negedge clk);
    #1;
    outs_zero("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
